// File: rtl/pipe_cpu_pkg.sv
// Shared types and constants for the pipelined CPU memory-side blocks.
// Holds the responder state encoding and the latency counter width.
package pipe_cpu_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam int WORD_BYTES = 4;
    localparam int OFF_W      = $clog2(WORD_BYTES);
    localparam int CNT_W      = 4;

endpackage

// File: rtl/dm_word_array.sv
// Word-wide data storage: synchronous write, combinational read.
// Deliberately unreset so it maps onto plain RAM/flop arrays.
module dm_word_array #(
    parameter int DEPTH = 128,
    parameter int AW    = 7
) (
    input  logic          clk,
    input  logic          wr_en,
    input  logic [AW-1:0] wr_addr,
    input  logic [31:0]   wr_data,
    input  logic [AW-1:0] rd_addr,
    output logic [31:0]   rd_data
);

    logic [31:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (wr_en) mem[wr_addr] <= wr_data;
    end

    assign rd_data = mem[rd_addr];

endmodule

// File: rtl/data_mem_responder.sv
// Single-outstanding load/store responder with fixed response latency.
// The array is touched only on the edge that enters RESP, so a reset in WAIT leaves it untouched.
module data_mem_responder
    import pipe_cpu_pkg::*;
#(
    parameter int DEPTH   = 128,
    parameter int LATENCY = 2
) (
    input  logic        clk_i,
    input  logic        rst_i,
    input  logic        req_valid_i,
    output logic        req_ready_o,
    input  logic        req_write_i,
    input  logic [31:0] req_addr_i,
    input  logic [31:0] req_wdata_i,
    output logic        rsp_valid_o,
    input  logic        rsp_ready_i,
    output logic [31:0] rsp_rdata_o,
    output logic        rsp_err_o
);

    localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

    state_t           state, state_nxt;
    logic [CNT_W-1:0] cnt;
    logic             wr_q;
    logic [31:0]      addr_q, wdata_q, rdata_q;
    logic             err_q;

    logic             accept, commit;
    logic             c_write, c_err;
    logic [31:0]      c_addr, c_wdata, arr_rdata;

    always_comb begin
        state_nxt   = state;
        accept      = 1'b0;
        commit      = 1'b0;
        req_ready_o = 1'b0;
        rsp_valid_o = 1'b0;
        case (state)
            IDLE: begin
                req_ready_o = 1'b1;
                if (req_valid_i) begin
                    accept = 1'b1;
                    if (LATENCY > 1) begin
                        state_nxt = WAIT;
                    end else begin
                        state_nxt = RESP;
                        commit    = 1'b1;
                    end
                end
            end
            WAIT: begin
                if (cnt == '0) begin
                    state_nxt = RESP;
                    commit    = 1'b1;
                end
            end
            RESP: begin
                rsp_valid_o = 1'b1;
                if (rsp_ready_i) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    // With LATENCY==1 the commit edge is the acceptance edge, so use the live request.
    assign c_write = (state == IDLE) ? req_write_i : wr_q;
    assign c_addr  = (state == IDLE) ? req_addr_i  : addr_q;
    assign c_wdata = (state == IDLE) ? req_wdata_i : wdata_q;
    assign c_err   = (c_addr[OFF_W-1:0] != '0) || (32'(c_addr[31:OFF_W]) >= 32'(DEPTH));

    dm_word_array #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_array (
        .clk     (clk_i),
        .wr_en   (commit && c_write && !c_err),
        .wr_addr (c_addr[AW+OFF_W-1:OFF_W]),
        .wr_data (c_wdata),
        .rd_addr (c_addr[AW+OFF_W-1:OFF_W]),
        .rd_data (arr_rdata)
    );

    always_ff @(posedge clk_i or negedge rst_i) begin
        if (!rst_i) begin
            state   <= IDLE;
            cnt     <= '0;
            wr_q    <= 1'b0;
            addr_q  <= '0;
            wdata_q <= '0;
            rdata_q <= '0;
            err_q   <= 1'b0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                cnt     <= CNT_W'(LATENCY - 1);
                wr_q    <= req_write_i;
                addr_q  <= req_addr_i;
                wdata_q <= req_wdata_i;
            end else if (state == WAIT && cnt != '0) begin
                cnt <= cnt - CNT_W'(1);
            end
            if (commit) begin
                err_q   <= c_err;
                rdata_q <= (c_err || c_write) ? '0 : arr_rdata;
            end
        end
    end

    assign rsp_rdata_o = rdata_q;
    assign rsp_err_o   = err_q;

endmodule
